adder_pipe_nbit: RTL and testbench
==================================

Name: adder_pipe_nbit

Overview:
Parametrised, pipelined ripple-carry adder. WIDTH-bit operands are split into CHUNK-bit slices, one slice per pipeline stage. Each stage registers its carry into the next, so the clock period is bounded by one CHUNK-bit add instead of WIDTH. A valid/ready stream handshake on input and output lets it sit directly in datapaths that apply backpressure.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of CHUNK, ≥1.
- CHUNK, 4, bits added per pipeline stage; 1 ≤ CHUNK ≤ WIDTH.
- STAGES (localparam), WIDTH/CHUNK, pipeline depth.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  a + b + c_in, modulo 2^WIDTH.
- c_out  output  1  carry out of bit WIDTH-1.

Behaviour:
- Clocking/reset: one clock. Reset is synchronous and active-low (rst_n sampled on rising clk). While rst_n=0 all stage valid bits clear, out_valid=0, sum=0, c_out=0. Data/carry registers may also clear. in_ready=0 during reset.
- Pipeline enable: adv = !out_valid || out_ready.
  - in_ready = adv, combinational from out_ready and out_valid. There is no combinational path from in_valid to in_ready.
  - When adv=1, all stages shift by one. When adv=0, every stage register holds (global stall).
- Transfers:
  - Input beat accepted when in_valid && in_ready.
  - Output beat consumed when out_valid && out_ready.
- Stage s (0..STAGES-1):
  - Computes {carry_s, sum_slice_s} = a_slice_s + b_slice_s + carry_{s-1}, where carry_{-1} = c_in.
  - Operands for slices above s ride a skew register chain.
  - Already-computed lower slices ride a deskew chain, so all slices of one beat exit together.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall; STAGES=1 means one registered cycle. Throughput: one beat per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, sum/c_out/out_valid hold stable and no beat is accepted.
- Bubbles propagate as valid=0 slots. They are not collapsed; a stall freezes bubbles too.
- Arithmetic is unsigned with wrap-around mod 2^WIDTH. c_out is the true carry. Inputs are not checked for X/Z.
- Simultaneous accept and consume in the same cycle is legal and required for full throughput.
- Reset asserted mid-operation discards all in-flight beats. First valid output after release appears STAGES cycles after the first post-reset accept.
- Parameter misuse (WIDTH % CHUNK ≠ 0): elaboration-time error via a generate-time check.

Optional Feature:
- Macro: ADDER_PIPE_NBIT_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow of the beat, = carry into MSB XOR carry out of MSB.
  - ovf is registered and aligned with sum.
  - ovf resets to 0 and holds under stall like sum.
- Undefined: port absent, no extra logic, all other behaviour identical.

Decomposition:
- Package adder_pipe_pkg:
  - function stages_f(width, chunk) returning WIDTH/CHUNK.
  - DEFAULT_WIDTH=16, DEFAULT_CHUNK=4.
  - typedef of the per-stage record {valid, carry, partial sum, pending operands}, parametrised through the package function/width constants.
- Sub-module adder_pipe_stage (parameter CHUNK):
  - Inputs: one slice add with registered carry, enable (adv), synchronous active-low reset.
  - Instantiated STAGES times in a generate loop.
  - The top holds the skew/deskew chains and handshake.

Test Plan (WIDTH=16, CHUNK=4):
- Reset then single beat: a=0xFFFF, b=0x0001, c_in=0 → out_valid rises exactly 4 cycles after accept, sum=0x0000, c_out=1.
- Carry-in ripple: a=0x0FFF, b=0x0000, c_in=1 → sum=0x1000, c_out=0 after 4 cycles. Confirms cross-stage carry.
- Back-to-back with out_ready=1: stream pairs (i, 3i) for i=0..31 → 32 consecutive out_valid cycles, in-order sums, in_ready held 1.
- Backpressure: hold out_ready=0 for 5 cycles with results pending → sum/c_out stable, in_ready=0, no beat lost or duplicated after release.
- Reset mid-flight: accept 3 beats, drive rst_n=0 for one cycle → out_valid=0 the next cycle, none of the 3 results ever appear.
- With ADDER_PIPE_NBIT_OVF_EN defined: a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, c_out=0. Then a=0x8000, b=0x8000 → sum=0x0000, ovf=1, c_out=1.

Source files
------------

// File: rtl/adder_pipe_nbit_pkg.sv
// Shared constants, stage-count helper and per-stage record for the pipelined adder.
package adder_pipe_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  function automatic int stages_f(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 0;
  endfunction

  localparam int DEFAULT_STAGES = stages_f(DEFAULT_WIDTH, DEFAULT_CHUNK);

  // Logical contents of one pipeline slot at the default geometry
  typedef struct packed {
    logic                     valid;
    logic                     carry;
    logic [DEFAULT_WIDTH-1:0] partialSum;
    logic [DEFAULT_WIDTH-1:0] pendA;
    logic [DEFAULT_WIDTH-1:0] pendB;
  } stage_rec_t;

endpackage

// File: rtl/adder_pipe_nbit_stage.sv
// One CHUNK-bit slice of the pipelined adder: combinational slice sum and a
// registered carry that feeds the next stage one cycle later.
module adder_pipe_stage
  import adder_pipe_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             carry_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             carry_o
);

  logic [CHUNK:0] total;
  logic           carry_d;
  logic           carry_q;

  assign total   = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, carry_i};
  assign sum_o   = total[CHUNK-1:0];
  assign carry_d = total[CHUNK];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (en_i) begin
      carry_q <= carry_d;
    end
  end

  assign carry_o = carry_q;

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined ripple-carry adder, one CHUNK-bit slice per stage, valid/ready on both sides.
// Defining ADDER_PIPE_NBIT_OVF_EN adds a registered signed-overflow output ovf.
module adder_pipe_nbit
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef ADDER_PIPE_NBIT_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = stages_f(WIDTH, CHUNK);
  localparam int LAST   = STAGES - 1;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("adder_pipe_nbit: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  logic              adv;
  logic              accept;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  opA      [STAGES];
  logic [WIDTH-1:0]  opB      [STAGES];
  logic [WIDTH-1:0]  rotA_d   [STAGES];
  logic [WIDTH-1:0]  rotA_q   [STAGES];
  logic [WIDTH-1:0]  rotB_d   [STAGES];
  logic [WIDTH-1:0]  rotB_q   [STAGES];
  logic [CHUNK-1:0]  sliceSum [STAGES];
  logic [STAGES-1:0] carryIn;
  logic [STAGES-1:0] carry;

  // Global stall: every slot moves together or nothing moves
  assign adv      = !valid_q[LAST] || out_ready;
  assign in_ready = rst_n && adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d    = valid_q << 1;
    valid_d[0] = accept;
  end

  // Each word rotates right by one slice per stage: the operand slice for the
  // next stage sits at the bottom while finished sum slices fill in from the top,
  // so after the last stage rotA holds the complete, deskewed sum.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [WIDTH-1:0] sliceWide;

    if (s == 0) begin : g_head
      assign opA[s]     = a;
      assign opB[s]     = b;
      assign carryIn[s] = c_in;
    end else begin : g_body
      assign opA[s]     = rotA_q[s-1];
      assign opB[s]     = rotB_q[s-1];
      assign carryIn[s] = carry[s-1];
    end

    adder_pipe_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (adv),
      .a_i    (opA[s][CHUNK-1:0]),
      .b_i    (opB[s][CHUNK-1:0]),
      .carry_i(carryIn[s]),
      .sum_o  (sliceSum[s]),
      .carry_o(carry[s])
    );

    always_comb begin
      sliceWide            = '0;
      sliceWide[CHUNK-1:0] = sliceSum[s];
    end

    assign rotA_d[s] = (opA[s] >> CHUNK) | (sliceWide << (WIDTH - CHUNK));
    assign rotB_d[s] = opB[s] >> CHUNK;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      rotA_q  <= '{default: '0};
      rotB_q  <= '{default: '0};
    end else if (adv) begin
      valid_q <= valid_d;
      rotA_q  <= rotA_d;
      rotB_q  <= rotB_d;
    end
  end

  // Outputs read as idle for the whole reset cycle, not just after the edge
  assign out_valid = rst_n && valid_q[LAST];
  assign sum       = rst_n ? rotA_q[LAST] : '0;
  assign c_out     = rst_n && carry[LAST];

`ifdef ADDER_PIPE_NBIT_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Same-sign operands producing an opposite-sign result, i.e. carry-in xor carry-out of the MSB
  assign ovf_d = (opA[LAST][CHUNK-1] == opB[LAST][CHUNK-1]) &&
                 (sliceSum[LAST][CHUNK-1] != opA[LAST][CHUNK-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = rst_n && ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Scoreboard bench for adder_pipe_nbit at WIDTH=16, CHUNK=4: directed beats push their
// hand-computed results into a queue and a negedge monitor checks every consumed output.
module tb_adder_pipe_nbit;
  import adder_pipe_pkg::*;

  localparam int WIDTH    = 16;
  localparam int CHUNK    = 4;
  localparam int STAGES   = 4;
  localparam int MAX_WAIT = 50;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  logic             clk;
  logic             rst_n;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] aIn;
  logic [WIDTH-1:0] bIn;
  logic             cIn;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] sumOut;
  logic             cOut;
`ifdef ADDER_PIPE_NBIT_OVF_EN
  logic             ovfOut;
`endif

  result_t expQ[$];
  int      testsRun    = 0;
  int      testsFailed = 0;
  int      runLen      = 0;
  int      maxRun      = 0;

  adder_pipe_nbit #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (inValid),
    .in_ready (inReady),
    .a        (aIn),
    .b        (bIn),
    .c_in     (cIn),
    .out_valid(outValid),
    .out_ready(outReady),
    .sum      (sumOut),
    .c_out    (cOut)
`ifdef ADDER_PIPE_NBIT_OVF_EN
    ,
    .ovf      (ovfOut)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat and hold it until accepted; the expected result is queued at the accepting edge
  task automatic applyStimulus(input logic [WIDTH-1:0] aVal, input logic [WIDTH-1:0] bVal,
                               input logic cVal, input logic [WIDTH-1:0] expSum,
                               input logic expCout, input logic expOvf, output int waits);
    bit      done;
    result_t rec;
    waits   = 0;
    done    = 0;
    aIn     = aVal;
    bIn     = bVal;
    cIn     = cVal;
    inValid = 1'b1;
    while (!done && waits < MAX_WAIT) begin
      @(negedge clk);
      if (inReady) begin
        rec.sum  = expSum;
        rec.cout = expCout;
        rec.ovf  = expOvf;
        expQ.push_back(rec);
        done = 1;
      end else begin
        waits++;
      end
      tick();
    end
    inValid = 1'b0;
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept timeout: got no accept in %0d cycles, required accept", waits);
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < MAX_WAIT) begin
      tick();
      n++;
    end
    checkOutput(name, expQ.size(), 0);
  endtask

  // Monitor: every consumed beat must match the oldest queued expectation
  initial begin
    result_t expRes;
    forever begin
      @(negedge clk);
      if (rst_n && outValid && outReady) begin
        runLen++;
        if (runLen > maxRun) maxRun = runLen;
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected beat: got sum=0x%04h c_out=%0b, required no output",
                   sumOut, cOut);
        end else begin
          expRes = expQ.pop_front();
          checkOutput("sum", sumOut, expRes.sum);
          checkOutput("c_out", cOut, expRes.cout);
`ifdef ADDER_PIPE_NBIT_OVF_EN
          checkOutput("ovf", ovfOut, expRes.ovf);
`endif
        end
      end else begin
        runLen = 0;
      end
    end
  end

  initial begin
    int waits;
    int stallTotal;
    int lat;
    rst_n    = 1'b0;
    inValid  = 1'b0;
    aIn      = '0;
    bIn      = '0;
    cIn      = 1'b0;
    outReady = 1'b1;
    repeat (2) tick();
    checkOutput("reset out_valid", outValid, 0);
    checkOutput("reset sum", sumOut, 0);
    checkOutput("reset c_out", cOut, 0);
    checkOutput("reset in_ready", inReady, 0);
`ifdef ADDER_PIPE_NBIT_OVF_EN
    checkOutput("reset ovf", ovfOut, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Single beat, wrap to zero with carry out, and its latency
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, waits);
    lat = 1;
    while (!outValid && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
    checkOutput("latency", lat, STAGES);
    waitDrain("drain single");

    applyStimulus(16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0, waits);
    waitDrain("drain carry ripple");

    // Full-throughput stream of (i, 3i)
    maxRun     = 0;
    stallTotal = 0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(WIDTH'(i), WIDTH'(3 * i), 1'b0, WIDTH'(4 * i), 1'b0, 1'b0, waits);
      stallTotal += waits;
    end
    waitDrain("drain stream");
    checkOutput("stream in_ready stalls", stallTotal, 0);
    checkOutput("stream consecutive outputs", maxRun, 32);

    // Backpressure with a full pipeline
    outReady = 1'b0;
    applyStimulus(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, waits);
    applyStimulus(16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0, waits);
    applyStimulus(16'hABCD, 16'h5432, 1'b1, 16'h0000, 1'b1, 1'b0, waits);
    applyStimulus(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, waits);
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall out_valid", outValid, 1);
      checkOutput("stall sum", sumOut, 16'h2345);
      checkOutput("stall c_out", cOut, 0);
      checkOutput("stall in_ready", inReady, 0);
      tick();
    end
    outReady = 1'b1;
    waitDrain("drain backpressure");

    // Reset with three beats in flight: none of them may emerge
    applyStimulus(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, waits);
    applyStimulus(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, waits);
    applyStimulus(16'h0005, 16'h0006, 1'b0, 16'h000B, 1'b0, 1'b0, waits);
    rst_n = 1'b0;
    expQ.delete();
    tick();
    checkOutput("mid reset out_valid", outValid, 0);
    rst_n = 1'b1;
    repeat (8) tick();
    applyStimulus(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, waits);
    lat = 1;
    while (!outValid && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
    checkOutput("latency after reset", lat, STAGES);
    waitDrain("drain after reset");

    // Signed overflow corner cases
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, waits);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, waits);
    waitDrain("drain overflow");

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
